// File: rtl/mips_run_controller_if.sv
// Control/status bundle between the board-level sequencer and the MIPS_DLX core.
// Step inputs appear only when RUN_CTRL_STEP_EN is defined.
interface mips_run_controller_if #(
  parameter int N_DOMAINS = 3,
  parameter int CNT_W     = 32
);
  logic                 start;
  logic                 halt_req;
  logic [N_DOMAINS-1:0] domain_rst_n;
  logic                 core_en;
  logic                 running;
  logic                 done;
  logic [CNT_W-1:0]     cycle_count;
`ifdef RUN_CTRL_STEP_EN
  logic                 step_mode;
  logic                 step;
`endif

  modport slave (
`ifdef RUN_CTRL_STEP_EN
    input  step_mode, step,
`endif
    input  start, halt_req,
    output domain_rst_n, core_en, running, done, cycle_count
  );

  modport master (
`ifdef RUN_CTRL_STEP_EN
    output step_mode, step,
`endif
    output start, halt_req,
    input  domain_rst_n, core_en, running, done, cycle_count
  );
endinterface

// File: rtl/mips_run_controller.sv
// Run/reset sequencer: hold reset, staggered domain release, run with cycle count, halt/restart.
// Optional single-step gating of core_en when RUN_CTRL_STEP_EN is defined.
module mips_run_controller #(
  parameter int RST_HOLD  = 16,
  parameter int N_DOMAINS = 3,
  parameter int STAGGER   = 4,
  parameter int CNT_W     = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  mips_run_controller_if.slave  ctl
);
  localparam int CW = $clog2(RST_HOLD + STAGGER + 1);
  localparam int IW = $clog2(N_DOMAINS + 1);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RELEASE, S_RUN, S_HALTED} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 core_en_q, core_en_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cyc_q, cyc_d;
  logic                 run_en;

`ifdef RUN_CTRL_STEP_EN
  assign run_en = ctl.step_mode ? ctl.step : 1'b1;
`else
  assign run_en = 1'b1;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '0;
      core_en_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      core_en_q <= core_en_d;
      running_q <= running_d;
      done_q    <= done_d;
      cyc_q     <= cyc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_d     = dom_q;
    core_en_d = core_en_q;
    running_d = running_q;
    done_d    = done_q;
    cyc_d     = cyc_q;
    // Count every edge the core was enabled, including the halting edge; saturate.
    if (core_en_q && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (ctl.start) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          dom_d   = '0;
          done_d  = 1'b0;
          cyc_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          state_d  = S_RELEASE;
          dom_d[0] = 1'b1;
          idx_d    = IW'(1);
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        // idx_q is the next domain to free; RUN follows one edge after the last one.
        if (idx_q == IW'(N_DOMAINS)) begin
          state_d   = S_RUN;
          running_d = 1'b1;
          core_en_d = run_en;
        end else if (cnt_q == CW'(STAGGER - 1)) begin
          for (int i = 0; i < N_DOMAINS; i++)
            if (IW'(i) == idx_q) dom_d[i] = 1'b1;
          idx_d = idx_q + IW'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (ctl.halt_req) begin
          state_d   = S_HALTED;
          core_en_d = 1'b0;
          running_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          core_en_d = run_en;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ctl.domain_rst_n = dom_q;
  assign ctl.core_en      = core_en_q;
  assign ctl.running      = running_q;
  assign ctl.done         = done_q;
  assign ctl.cycle_count  = cyc_q;
endmodule

// File: tb/tb_mips_run_controller.sv
// Directed bench: default-parameter sequencer plus a CNT_W=4, single-domain instance.
module tb_mips_run_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_run_controller_if #(.N_DOMAINS(3), .CNT_W(32)) ia ();
  mips_run_controller_if #(.N_DOMAINS(1), .CNT_W(4))  ib ();

  mips_run_controller #(.RST_HOLD(16), .N_DOMAINS(3), .STAGGER(4), .CNT_W(32)) dut_a (
    .clock_i(clk), .reset_i(rst_n), .ctl(ia));
  mips_run_controller #(.RST_HOLD(2), .N_DOMAINS(1), .STAGGER(1), .CNT_W(4)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .ctl(ib));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed as {domain_rst_n, core_en, running, done, cycle_count}.
  task automatic chk_a(string tag, logic [2:0] d, logic ce, logic r, logic dn, logic [31:0] c);
    chk(tag, 64'({ia.domain_rst_n, ia.core_en, ia.running, ia.done, ia.cycle_count}),
             64'({d, ce, r, dn, c}));
  endtask

  task automatic chk_b(string tag, logic d, logic ce, logic r, logic dn, logic [3:0] c);
    chk(tag, 64'({ib.domain_rst_n, ib.core_en, ib.running, ib.done, ib.cycle_count}),
             64'({d, ce, r, dn, c}));
  endtask

  // Called just after edge 0; walks edges 1..25 of the default-parameter sequence.
  task automatic seq_a(string tag);
    logic [2:0] d;
    logic       ce;
    for (int e = 1; e <= 25; e++) begin
      tick();
      d  = (e >= 24) ? 3'b111 : (e >= 20) ? 3'b011 : (e >= 16) ? 3'b001 : 3'b000;
      ce = (e >= 25);
      chk_a($sformatf("%s_e%0d", tag, e), d, ce, ce, 1'b0, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ia.start = 1'b0; ia.halt_req = 1'b0;
    ib.start = 1'b0; ib.halt_req = 1'b0;
`ifdef RUN_CTRL_STEP_EN
    ia.step_mode = 1'b0; ia.step = 1'b0;
    ib.step_mode = 1'b0; ib.step = 1'b0;
`endif
    repeat (10) tick();
    chk_a("reset_a", 3'b000, 0, 0, 0, 0);
    chk_b("reset_b", 1'b0, 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_a("idle", 3'b000, 0, 0, 0, 0);

    // Start pulse, then staggered release
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    chk_a("edge0", 3'b000, 0, 0, 0, 0);
    seq_a("seq1");

    // Ten enabled edges, halt on the tenth, then hold halt
    repeat (9) tick();
    chk_a("run9", 3'b111, 1, 1, 0, 9);
    ia.halt_req = 1'b1; tick();
    chk_a("halt", 3'b111, 0, 0, 1, 10);
    repeat (5) tick();
    chk_a("halt_held", 3'b111, 0, 0, 1, 10);

    // Restart from HALTED with halt_req still high: start wins
    ia.start = 1'b1; tick(); ia.start = 1'b0; ia.halt_req = 1'b0;
    chk_a("restart", 3'b000, 0, 0, 0, 0);
    seq_a("seq2");

    // Start and halt together in RUN: halt wins
    repeat (2) tick();
    chk_a("run2", 3'b111, 1, 1, 0, 2);
    ia.start = 1'b1; ia.halt_req = 1'b1; tick(); ia.start = 1'b0; ia.halt_req = 1'b0;
    chk_a("halt_wins", 3'b111, 0, 0, 1, 3);

    // Async reset in the middle of RELEASE
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    repeat (21) tick();
    chk_a("rel21", 3'b011, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_a("async_rst", 3'b000, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_a("post_rst_idle", 3'b000, 0, 0, 0, 0);
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    seq_a("seq3");

    // Single domain, 4-bit counter saturation
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    tick(); chk_b("b_hold", 1'b0, 0, 0, 0, 0);
    tick(); chk_b("b_release", 1'b1, 0, 0, 0, 0);
    tick(); chk_b("b_run", 1'b1, 1, 1, 0, 0);
    repeat (14) tick(); chk_b("b_cnt14", 1'b1, 1, 1, 0, 14);
    tick();             chk_b("b_cnt15", 1'b1, 1, 1, 0, 15);
    repeat (5) tick();  chk_b("b_sat", 1'b1, 1, 1, 0, 15);

`ifdef RUN_CTRL_STEP_EN
    ib.halt_req = 1'b1; tick(); ib.halt_req = 1'b0;
    chk_b("b_halt", 1'b1, 0, 0, 1, 15);
    ib.step_mode = 1'b1;
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    repeat (3) tick();
    chk_b("step_run", 1'b1, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      ib.step = 1'b1; tick(); ib.step = 1'b0;
      chk_b($sformatf("step%0d_en", k), 1'b1, 1, 1, 0, 4'(k - 1));
      tick();
      chk_b($sformatf("step%0d_off", k), 1'b1, 0, 1, 0, 4'(k));
    end
    repeat (3) tick();
    chk_b("step_total", 1'b1, 0, 1, 0, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
